spi_slave_ctrl: RTL and testbench
=================================

Name: spi_slave_ctrl

Overview:
- Oversampling SPI target (slave) controller for the same SPI bus the existing master drives.
- Synchronises SCL/CS_n/MOSI into the system clock domain and deserialises MOSI into rx_data with an rx_valid pulse.
- Serialises tx_data onto MISO at the same time.
- Supports all four SPI modes; 8-bit frames, MSB first, back-to-back bytes within one CS_n assertion.

Parameters:
- DATA_W, 8, frame width in bits.
- SYNC_STAGES, 2, synchroniser depth for SCL, CS_n and MOSI (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  SPI mode: mode[1]=CPOL, mode[0]=CPHA.
- SCL  input  1  SPI serial clock from master.
- CS_n  input  1  active-low chip select from master.
- MOSI  input  1  serial data from master.
- tx_data  input  DATA_W  byte to return on MISO; sampled at frame/byte start.
- MISO  output  1  serial data to master.
- rx_data  output  DATA_W  last fully received byte.
- rx_valid  output  1  one-clk pulse: rx_data updated.
- busy  output  1  high while a frame is active (synced CS_n low).
- frame_err  output  1  one-clk pulse: CS_n deasserted mid-byte.

Behaviour:
- Interface and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - Reset values: MISO=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, state=IDLE, bit counter=0, shift registers=0, synchronisers preset to idle (CS_n=1, SCL=0, MOSI=0).
- Input path: SCL, CS_n and MOSI each pass through SYNC_STAGES flops, plus one history flop for edge detection.
- Edge classification (synced SCL):
  - Leading edge = transition away from CPOL level; trailing edge = transition back to it.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1. The other edge is the shift edge.
- mode is latched on the synced CS_n falling edge. mode changes during a frame are ignored until the next frame.
- State machine:
  - IDLE: MISO=0. On synced CS_n fall:
    - latch mode; load tx shift register with tx_data; clear bit counter; busy=1; go to ACTIVE.
    - If CPHA=0, MISO=tx_data[DATA_W-1] on the next clk.
  - ACTIVE, sample edge: shift synced MOSI into rx shift register LSB; bit counter +1.
  - ACTIVE, shift edge:
    - CPHA=0: shift tx register left; MISO = new MSB.
    - CPHA=1: on the first leading edge of a byte MISO = tx MSB; later leading edges shift.
    - No shift-edge action after the final sample edge of a byte.
  - Byte complete (counter reaches DATA_W on a sample edge):
    - next clk: rx_data <= assembled byte; rx_valid=1 for exactly one clk; counter=0.
    - reload tx shift register from current tx_data; if CPHA=0, MISO presents its MSB.
    - Stay in ACTIVE to support back-to-back bytes.
  - ACTIVE, synced CS_n rise:
    - Counter=0: clean end of frame. Return to IDLE, busy=0, MISO=0.
    - Counter 1..DATA_W-1: abort. Partial byte discarded, rx_data unchanged, no rx_valid, frame_err=1 for one clk, return to IDLE.
  - Simultaneous completion sample edge and CS_n rise in the same clk: byte completes (rx_valid pulses), no frame_err, return to IDLE.
- Latency: rx_valid asserts SYNC_STAGES+2 clk cycles after the 8th raw sample edge on SCL.
- Reset mid-frame: all state cleared immediately. The frame is lost silently; no rx_valid or frame_err is generated.
- Glitch robustness: SCL edges while synced CS_n is high are ignored.

Test Plan:
- Mode 0, tx_data=0x3C, master sends 0xA5 -> rx_data=0xA5 with one rx_valid pulse; master receives 0x3C; busy high for the whole frame.
- Mode 3, tx_data=0xC3, master sends 0x5A -> rx_data=0x5A; master receives 0xC3.
- Modes 1 and 2, master sends 0x81 and 0x7E -> correct rx_data; MISO bits are stable across every master sampling edge.
- Back-to-back bytes 0x11 then 0x22 under one CS_n low, tx_data changed 0xAA->0x55 between bytes -> two rx_valid pulses (0x11, 0x22); master receives 0xAA then 0x55.
- CS_n raised after 5 bits of 0xF0 -> frame_err pulses once, no rx_valid, rx_data keeps its previous value, busy=0, MISO=0.
- rst_n asserted after 4 bits -> all outputs 0 immediately. A following full 0x96 frame -> rx_data=0x96 with no residue from the aborted frame.

Source files
------------

// File: rtl/spi_slave_ctrl.sv
// Oversampling SPI target: synchronises SCL/CS_n/MOSI, receives into
// rx_data and returns tx_data on MISO, all four modes, MSB first.
module spi_slave_ctrl #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              SCL,
  input  logic              CS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   scl_h;
  logic                   cs_h;

  logic              scl_s;
  logic              cs_s;
  logic              mosi_s;
  logic              cs_fall;
  logic              cs_rise;
  logic              lead;
  logic              trail;
  logic              smp;
  logic              shf;
  logic              last;
  logic              pend;
  logic [1:0]        mode_q;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_sr;
  logic              miso_q;

  // Synchronisers preset to the idle bus: CS_n high, SCL and MOSI low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      scl_h     <= 1'b0;
      cs_h      <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], SCL};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      scl_h     <= scl_sync[SYNC_STAGES-1];
      cs_h      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s   = scl_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign cs_fall = cs_h & ~cs_s;
  assign cs_rise = ~cs_h & cs_s;

  // Leading edge leaves the CPOL idle level, trailing edge returns to it.
  assign lead    = mode_q[1] ? (scl_h & ~scl_s) : (~scl_h & scl_s);
  assign trail   = (scl_h ^ scl_s) & ~lead;
  assign smp     = mode_q[0] ? trail : lead;
  assign shf     = mode_q[0] ? lead : trail;
  assign last    = smp && (cnt == CW'(DATA_W - 1));
  assign pend    = (cnt == CW'(DATA_W));
  assign rx_next = {rx_sr[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ACTIVE);
    MISO = miso_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 2'b00;
      cnt       <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      miso_q    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall) begin
            mode_q <= mode;
            tx_sr  <= tx_data;
            cnt    <= '0;
            rx_sr  <= '0;
            miso_q <= mode[0] ? 1'b0 : tx_data[DATA_W-1];
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            miso_q <= 1'b0;
            cnt    <= '0;
            rx_sr  <= '0;
            if (last) begin
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end else if (pend) begin
              rx_data  <= rx_sr;
              rx_valid <= 1'b1;
            end else if (cnt != '0) begin
              frame_err <= 1'b1;
            end
          end else if (pend) begin
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            cnt      <= '0;
            tx_sr    <= tx_data;
            if (!mode_q[0]) miso_q <= tx_data[DATA_W-1];
          end else if (smp) begin
            rx_sr <= rx_next;
            cnt   <= cnt + CW'(1);
          end else if (shf) begin
            // cnt==0: CPHA=1 presents the MSB; CPHA=0 has nothing left to shift.
            if (mode_q[0] && cnt == '0) begin
              miso_q <= tx_sr[DATA_W-1];
            end else if (cnt != '0) begin
              tx_sr  <= tx_sr << 1;
              miso_q <= tx_sr[DATA_W-2];
            end
          end
        end
        default: miso_q <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: bit-banged master, rx scoreboard,
// immediate assertions on every comparison.
module tb_spi_slave_ctrl;

  localparam int HP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       SCL = 1'b0;
  logic       CS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       MISO;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_ferr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;

  spi_slave_ctrl #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .SCL       (SCL),
    .CS_n      (CS_n),
    .MOSI      (MOSI),
    .tx_data   (tx_data),
    .MISO      (MISO),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL rx_unexpected got=%h exp=none", rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        assert (rx_data === mon_e) else begin
          failures++;
          $error("FAIL rx_data got=%h exp=%h", rx_data, mon_e);
        end
      end
    end
    if (frame_err) n_ferr++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input logic [1:0] m);
    mode = m;
    SCL  = m[1];
    MOSI = 1'b0;
    tick(6);
  endtask

  task automatic cs_low();
    CS_n = 1'b0;
    tick(HP);
  endtask

  task automatic cs_high();
    tick(HP);
    CS_n = 1'b1;
    tick(HP);
  endtask

  task automatic xfer(input logic [1:0] m, input logic [7:0] mo,
                      input int nbits, output logic [7:0] mi);
    logic cpol;
    logic cpha;
    logic pre;
    cpol = m[1];
    cpha = m[0];
    mi   = 8'h00;
    pre  = 1'b0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) MOSI = mo[i];
      tick(HP - 2);
      if (!cpha) pre = MISO;
      tick(2);
      SCL = ~cpol;
      if (cpha) begin
        MOSI = mo[i];
      end else begin
        mi[i] = MISO;
        chk("miso_stable", mi[i], pre);
      end
      tick(HP - 2);
      if (cpha) pre = MISO;
      tick(2);
      SCL = cpol;
      if (cpha) begin
        mi[i] = MISO;
        chk("miso_stable", mi[i], pre);
      end
    end
  endtask

  task automatic frame(input logic [1:0] m, input logic [7:0] txb,
                       input logic [7:0] mo, input string tag);
    logic [7:0] mi;
    int v0;
    v0 = n_valid;
    setup(m);
    tx_data = txb;
    cs_low();
    chk({tag, "_busy_on"}, busy, 1);
    exp_q.push_back(mo);
    xfer(m, mo, 8, mi);
    chk({tag, "_busy_mid"}, busy, 1);
    cs_high();
    chk({tag, "_miso_rx"}, mi, txb);
    chk({tag, "_valid_cnt"}, n_valid - v0, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_miso_idle"}, MISO, 0);
  endtask

  initial begin
    logic [7:0] mi;
    int v0;
    int f0;

    rst_n = 1'b0;
    tick(3);
    chk("rst_miso", MISO, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    tick(4);

    frame(2'd0, 8'h3C, 8'hA5, "m0");
    frame(2'd3, 8'hC3, 8'h5A, "m3");
    frame(2'd1, 8'h96, 8'h81, "m1");
    frame(2'd2, 8'h69, 8'h7E, "m2");

    // Back-to-back: tx_data updated after the first byte is loaded.
    v0 = n_valid;
    setup(2'd0);
    tx_data = 8'hAA;
    cs_low();
    tx_data = 8'h55;
    exp_q.push_back(8'h11);
    xfer(2'd0, 8'h11, 8, mi);
    chk("b2b_miso_1", mi, 8'hAA);
    exp_q.push_back(8'h22);
    xfer(2'd0, 8'h22, 8, mi);
    chk("b2b_miso_2", mi, 8'h55);
    cs_high();
    chk("b2b_valid_cnt", n_valid - v0, 2);
    chk("b2b_rx_data", rx_data, 8'h22);

    // Abort after 5 bits.
    v0 = n_valid;
    f0 = n_ferr;
    setup(2'd0);
    tx_data = 8'h00;
    cs_low();
    xfer(2'd0, 8'hF0, 5, mi);
    cs_high();
    chk("abort_ferr_cnt", n_ferr - f0, 1);
    chk("abort_valid_cnt", n_valid - v0, 0);
    chk("abort_rx_data", rx_data, 8'h22);
    chk("abort_busy", busy, 0);
    chk("abort_miso", MISO, 0);

    // Reset in the middle of a frame.
    v0 = n_valid;
    f0 = n_ferr;
    setup(2'd0);
    tx_data = 8'hFF;
    cs_low();
    xfer(2'd0, 8'hFF, 4, mi);
    tick(2);
    rst_n = 1'b0;
    #1;
    chk("mrst_miso", MISO, 0);
    chk("mrst_rx_data", rx_data, 0);
    chk("mrst_rx_valid", rx_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_frame_err", frame_err, 0);
    CS_n = 1'b1;
    SCL  = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(6);
    chk("mrst_valid_cnt", n_valid - v0, 0);
    chk("mrst_ferr_cnt", n_ferr - f0, 0);
    frame(2'd0, 8'h5A, 8'h96, "post");
    chk("post_rx_data", rx_data, 8'h96);

    tick(10);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
